// File: rtl/serial_mult_ctrl.sv
// Sequencer for a bit-serial shift-add multiplier. It accepts an operand pair, streams x LSB-first, then captures and hands off the product.
// Optional build macro SERIAL_MULT_SELFCHECK_EN adds a sticky chk_err_o output that compares the product against x*y.
module serial_mult_ctrl #(
  parameter int unsigned WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     x_in_i,
  input  logic [WIDTH-1:0]     y_in_i,
  output logic                 mult_a_o,
  output logic [WIDTH-1:0]     mult_b_o,
  output logic                 mult_start_o,
  output logic                 mult_done_o,
  input  logic [2*WIDTH-1:0]   mult_out_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
`ifdef SERIAL_MULT_SELFCHECK_EN
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 chk_err_o
`else
  output logic [2*WIDTH-1:0]   result_o
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [WIDTH-1:0] mult_b_q, mult_b_d;
  logic [PW-1:0]   result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            mult_start_q, mult_start_d;
  logic            mult_done_q, mult_done_d;
  logic            mult_a_q, mult_a_d;
  logic            accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      x_sh_q       <= '0;
      mult_b_q     <= '0;
      result_q     <= '0;
      out_valid_q  <= 1'b0;
      mult_start_q <= 1'b0;
      mult_done_q  <= 1'b1;
      mult_a_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_sh_q       <= x_sh_d;
      mult_b_q     <= mult_b_d;
      result_q     <= result_d;
      out_valid_q  <= out_valid_d;
      mult_start_q <= mult_start_d;
      mult_done_q  <= mult_done_d;
      mult_a_q     <= mult_a_d;
    end
  end

  // Multiplier controls are decoded from the next state so they line up with the state register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_sh_d      = x_sh_q;
    mult_b_d    = mult_b_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_o  = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        accept     = in_valid_i;
      end
      S_START: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        x_sh_d = x_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d    = mult_out_i;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          accept      = in_valid_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      x_sh_d   = x_in_i;
      mult_b_d = y_in_i;
      state_d  = S_START;
    end

    mult_start_d = (state_d == S_START);
    mult_done_d  = !((state_d == S_START) || (state_d == S_RUN));
    mult_a_d     = (state_d == S_RUN) && x_sh_d[0];
  end

  assign mult_a_o     = mult_a_q;
  assign mult_b_o     = mult_b_q;
  assign mult_start_o = mult_start_q;
  assign mult_done_o  = mult_done_q;
  assign out_valid_o  = out_valid_q;
  assign result_o     = result_q;

`ifdef SERIAL_MULT_SELFCHECK_EN
  logic [WIDTH-1:0] x_lat_q, x_lat_d;
  logic             chk_err_q, chk_err_d;

  // Independent copy of x, because x_sh is consumed by the shift.
  always_comb begin
    x_lat_d   = x_lat_q;
    chk_err_d = chk_err_q;
    if (accept) x_lat_d = x_in_i;
    if ((state_q == S_DONE) && (mult_out_i != (PW'(x_lat_q) * PW'(mult_b_q))))
      chk_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat_q   <= '0;
      chk_err_q <= 1'b0;
    end else begin
      x_lat_q   <= x_lat_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err_o = chk_err_q;
`endif

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Testbench for serial_mult_ctrl. It includes a behavioural serial multiplier and checks products against x*y.
module tb_serial_mult_ctrl;

  localparam int unsigned WIDTH = 7;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int          LAT   = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             mult_start;
  logic             mult_done;
  logic [PW-1:0]    mult_out;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    result;
`ifdef SERIAL_MULT_SELFCHECK_EN
  logic             chk_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .x_in_i       (x_in),
    .y_in_i       (y_in),
    .mult_a_o     (mult_a),
    .mult_b_o     (mult_b),
    .mult_start_o (mult_start),
    .mult_done_o  (mult_done),
    .mult_out_i   (mult_out),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
`ifdef SERIAL_MULT_SELFCHECK_EN
    .result_o     (result),
    .chk_err_o    (chk_err)
`else
    .result_o     (result)
`endif
  );

  // Model of the downstream shift-add multiplier. It clears while done or start is high and accumulates b<<i for each serial 1 bit.
  logic [PW-1:0] acc;
  int            bit_idx;
  logic          corrupt = 1'b0;

  always @(posedge clk) begin
    if (mult_done || mult_start) begin
      acc     <= '0;
      bit_idx <= 0;
    end else begin
      if (mult_a) acc <= acc + (PW'(mult_b) << bit_idx);
      bit_idx <= bit_idx + 1;
    end
  end

  assign mult_out = corrupt ? (acc ^ PW'(1)) : acc;

  // Offer one operand pair and wait for the result. lat counts negedges after acceptance (0 = START) and is -1 on timeout.
  task automatic do_op(input int x, input int y, output logic [PW-1:0] res, output int lat);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = WIDTH'(x);
    y_in     = WIDTH'(y);
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    lat = -1;
    res = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mult_done !== 1'b1 || mult_start !== 1'b0 || mult_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: out_valid=%b done=%b start=%b a=%b required 0 1 0 0",
               out_valid, mult_done, mult_start, mult_a);
    end
    checks++;
    if (result !== '0 || mult_b !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_data: result=%0d mult_b=%0d in_ready=%b required 0 0 1", result, mult_b, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic st[16];
    logic aa[16];
    logic dn[16];
    logic [WIDTH-1:0] bb[16];
    int   first_ov;
    int   x;
    int   y;
    int   nstart;
    logic [PW-1:0] res_at;
    x = 5;
    y = 3;
    first_ov = -1;
    res_at = '0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = WIDTH'(x);
    y_in      = WIDTH'(y);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      st[k] = mult_start;
      aa[k] = mult_a;
      dn[k] = mult_done;
      bb[k] = mult_b;
      if (out_valid && first_ov < 0) begin
        first_ov = k;
        res_at   = result;
      end
    end
    nstart = 0;
    for (int k = 0; k < 16; k++) if (st[k]) nstart++;
    checks++;
    if (nstart != 1 || st[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_start: pulses=%0d first=%b required 1 pulse at k=0", nstart, st[0]);
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      checks++;
      if (aa[i+1] !== 1'((x >> i) & 1)) begin
        failures++;
        $display("FAIL basic_serial_bit%0d: mult_a=%b required %0d", i, aa[i+1], (x >> i) & 1);
      end
    end
    checks++;
    if (dn[0] !== 1'b0 || dn[WIDTH] !== 1'b0 || dn[WIDTH+1] !== 1'b1 || bb[3] !== WIDTH'(y)) begin
      failures++;
      $display("FAIL basic_done_b: done k0=%b k%0d=%b k%0d=%b mult_b=%0d required 0 0 1 %0d",
               dn[0], WIDTH, dn[WIDTH], WIDTH+1, dn[WIDTH+1], bb[3], y);
    end
    checks++;
    if (first_ov != LAT) begin
      failures++;
      $display("FAIL basic_latency: out_valid at k=%0d required %0d", first_ov, LAT);
    end
    checks++;
    if (res_at !== PW'(15)) begin
      failures++;
      $display("FAIL basic_result: result=%0d required 15", res_at);
    end
  endtask

  task automatic test_corners();
    int xs[4] = '{127, 0, 1, 127};
    int ys[4] = '{127, 99, 127, 1};
    logic [PW-1:0] res;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(xs[i], ys[i], res, lat);
      checks++;
      if (res !== PW'(xs[i] * ys[i]) || lat != LAT) begin
        failures++;
        $display("FAIL corner_%0dx%0d: result=%0d lat=%0d required %0d lat %0d",
                 xs[i], ys[i], res, lat, xs[i] * ys[i], LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int xa;
    int ya;
    int w;
    int lat;
    logic [PW-1:0] res;
    xa = int'($urandom_range(1, 127));
    ya = int'($urandom_range(1, 127));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_in      = WIDTH'(xa);
    y_in      = WIDTH'(ya);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x_in     = WIDTH'(100);
      y_in     = WIDTH'(100);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== PW'(xa * ya) || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: out_valid=%b result=%0d in_ready=%b required 1 %0d 0",
                 i, out_valid, result, in_ready, xa * ya);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    x_in      = WIDTH'(2);
    y_in      = WIDTH'(9);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mult_start !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_direct_start: start=%b out_valid=%b required 1 0", mult_start, out_valid);
    end
    lat = -1;
    res = 'x;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        res = result;
        break;
      end
    end
    checks++;
    if (res !== PW'(18) || lat != LAT) begin
      failures++;
      $display("FAIL hold_next_result: result=%0d lat=%0d required 18 lat %0d", res, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int xs[4];
    int ys[4];
    int acc_cyc[4];
    int res_cyc[4];
    logic [PW-1:0] res[4];
    int offer;
    int ngot;
    int cyc;
    bit pending;
    for (int i = 0; i < 4; i++) begin
      xs[i] = int'($urandom_range(0, 127));
      ys[i] = int'($urandom_range(0, 127));
      acc_cyc[i] = -100;
      res_cyc[i] = -100;
      res[i] = 'x;
    end
    @(negedge clk);
    out_ready = 1'b1;
    offer   = 0;
    ngot    = 0;
    cyc     = 0;
    pending = 1'b0;
    in_valid = 1'b1;
    x_in = WIDTH'(xs[0]);
    y_in = WIDTH'(ys[0]);
    #1;
    if (in_ready) begin
      acc_cyc[0] = 0;
      pending = 1'b1;
    end
    while (ngot < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pending) begin
        pending = 1'b0;
        offer++;
        if (offer < 4) begin
          x_in = WIDTH'(xs[offer]);
          y_in = WIDTH'(ys[offer]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        res[ngot]     = result;
        res_cyc[ngot] = cyc;
        ngot++;
      end
      #1;
      if (in_valid && in_ready && offer < 4) begin
        acc_cyc[offer] = cyc;
        pending = 1'b1;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== PW'(xs[i] * ys[i])) begin
        failures++;
        $display("FAIL b2b_result%0d: result=%0d required %0d (x=%0d y=%0d)",
                 i, res[i], xs[i] * ys[i], xs[i], ys[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != LAT + 1 || res_cyc[i] - res_cyc[i-1] != LAT + 1) begin
        failures++;
        $display("FAIL b2b_spacing%0d: accept gap=%0d result gap=%0d required %0d",
                 i, acc_cyc[i] - acc_cyc[i-1], res_cyc[i] - res_cyc[i-1], LAT + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen_ov;
    int lat;
    logic [PW-1:0] res;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x_in      = WIDTH'($urandom_range(64, 127));
    y_in      = WIDTH'($urandom_range(64, 127));
    @(posedge clk);
    // k=0 is START; RUN with cnt=3 is k=4.
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mult_done !== 1'b1 || mult_start !== 1'b0 || mult_a !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctl: done=%b start=%b a=%b out_valid=%b required 1 0 0 0",
               mult_done, mult_start, mult_a, out_valid);
    end
    checks++;
    if (result !== '0 || mult_b !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_data: result=%0d mult_b=%0d in_ready=%b required 0 0 1", result, mult_b, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen_ov++;
    end
    checks++;
    if (seen_ov != 0) begin
      failures++;
      $display("FAIL midreset_no_valid: out_valid cycles=%0d required 0", seen_ov);
    end
    do_op(6, 7, res, lat);
    checks++;
    if (res !== PW'(42) || lat != LAT) begin
      failures++;
      $display("FAIL midreset_next: result=%0d lat=%0d required 42 lat %0d", res, lat, LAT);
    end
  endtask

  task automatic test_random();
    int x;
    int y;
    int lat;
    logic [PW-1:0] res;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(0, 127));
      y = int'($urandom_range(0, 127));
      do_op(x, y, res, lat);
      checks++;
      if (res !== PW'(x * y) || lat != LAT) begin
        failures++;
        $display("FAIL random%0d: result=%0d lat=%0d required %0d lat %0d (x=%0d y=%0d)",
                 i, res, lat, x * y, LAT, x, y);
      end
    end
  endtask

`ifdef SERIAL_MULT_SELFCHECK_EN
  task automatic test_selfcheck();
    int lat;
    logic [PW-1:0] res;
    out_ready = 1'b1;
    do_op(9, 10, res, lat);
    checks++;
    if (chk_err !== 1'b0) begin
      failures++;
      $display("FAIL selfcheck_clean: chk_err=%b required 0", chk_err);
    end
    corrupt = 1'b1;
    do_op(9, 10, res, lat);
    corrupt = 1'b0;
    do_op(3, 4, res, lat);
    checks++;
    if (chk_err !== 1'b1) begin
      failures++;
      $display("FAIL selfcheck_sticky: chk_err=%b required 1", chk_err);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (chk_err !== 1'b0) begin
      failures++;
      $display("FAIL selfcheck_reset: chk_err=%b required 0", chk_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SERIAL_MULT_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
